countdown_timer: RTL and testbench

COUNTDOWN_TIMER -- requirements
Module: countdown_timer

---
 rtl/countdown_timer.sv | 97 +++++++++
 tb/tb_countdown_timer.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/countdown_timer.sv
// Loadable down-counter with pause/abort, optional auto-reload and a
// registered terminal-count pulse with a wrapping pulse counter.
module countdown_timer #(
  parameter int WIDTH = 4
) (
  input  logic             CLOCK,
  input  logic             CLEAR,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] LOAD_VAL,
  input  logic             START,
  input  logic             STOP,
  input  logic             RELOAD_EN,
  output logic [WIDTH-1:0] Q,
  output logic             BUSY,
  output logic             DONE,
  output logic             TC,
  output logic [3:0]       TC_CNT
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]       state;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] rld;
  logic             tc;
  logic [3:0]       tc_cnt;

  always_ff @(posedge CLOCK) begin
    if (CLEAR) begin
      state  <= ST_IDLE;
      count  <= ZERO;
      rld    <= ZERO;
      tc     <= 1'b0;
      tc_cnt <= 4'h0;
    end else begin
      tc <= 1'b0;
      if (LOAD) begin
        count <= LOAD_VAL;
        rld   <= LOAD_VAL;
        if (state == ST_RUN && LOAD_VAL != ZERO)
          state <= ST_RUN;
        else
          state <= ST_IDLE;
      end else if (STOP) begin
        // STOP pauses a running count and aborts a paused one
        if (state == ST_RUN)
          state <= ST_PAUSE;
        else if (state == ST_PAUSE)
          state <= ST_IDLE;
      end else if (START && state != ST_RUN) begin
        case (state)
          ST_IDLE: begin
            if (count != ZERO)
              state <= ST_RUN;
          end
          ST_PAUSE: state <= ST_RUN;
          ST_DONE: begin
            if (rld != ZERO) begin
              count <= rld;
              state <= ST_RUN;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end else if (state == ST_RUN) begin
        if (count > ONE) begin
          count <= count - ONE;
        end else if (count == ONE) begin
          tc     <= 1'b1;
          tc_cnt <= tc_cnt + 4'h1;
          if (RELOAD_EN) begin
            count <= rld;
          end else begin
            count <= ZERO;
            state <= ST_DONE;
          end
        end else begin
          // Zero count in RUN is unreachable; fall back to IDLE without a pulse
          state <= ST_IDLE;
        end
      end
    end
  end

  assign Q      = count;
  assign TC     = tc;
  assign TC_CNT = tc_cnt;
  assign BUSY   = (state == ST_RUN) || (state == ST_PAUSE);
  assign DONE   = (state == ST_DONE);

endmodule

// File: tb/tb_countdown_timer.sv
// Directed vector bench for countdown_timer: one table row per clock edge,
// followed by a bounded latency measurement.
module tb_countdown_timer;

  logic       clk;
  logic       clear, load, start, stop, reload_en;
  logic [3:0] load_val;
  logic [3:0] q;
  logic       busy, done, tc;
  logic [3:0] tc_cnt;

  int total = 0;
  int bad   = 0;

  countdown_timer #(.WIDTH(4)) dut (
    .CLOCK(clk), .CLEAR(clear), .LOAD(load), .LOAD_VAL(load_val),
    .START(start), .STOP(stop), .RELOAD_EN(reload_en),
    .Q(q), .BUSY(busy), .DONE(done), .TC(tc), .TC_CNT(tc_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       c, l;
    logic [3:0] v;
    logic       s, p, r;
    logic [3:0] eq;
    logic       eb, ed, et;
    logic [3:0] en;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic c, input logic l, input logic [3:0] v,
                     input logic s, input logic p, input logic r,
                     input logic [3:0] eq, input logic eb, input logic ed,
                     input logic et, input logic [3:0] en);
    vec_t x;
    x.c = c; x.l = l; x.v = v; x.s = s; x.p = p; x.r = r;
    x.eq = eq; x.eb = eb; x.ed = ed; x.et = et; x.en = en;
    vecs.push_back(x);
  endtask

  task automatic drive(input logic c, input logic l, input logic [3:0] v,
                       input logic s, input logic p, input logic r);
    clear = c; load = l; load_val = v; start = s; stop = p; reload_en = r;
  endtask

  initial begin
    logic [3:0] n;
    logic [10:0] act, exp;
    int edges;

    drive(0, 0, 0, 0, 0, 0);

    //   c l v  s p r   q  b d t n
    add(1,0,0, 0,0,0,  0, 0,0,0,0);
    add(1,0,0, 0,0,0,  0, 0,0,0,0);
    // single shot from 3
    add(0,1,3, 0,0,0,  3, 0,0,0,0);
    add(0,0,0, 1,0,0,  3, 1,0,0,0);
    add(0,0,0, 0,0,0,  2, 1,0,0,0);
    add(0,0,0, 0,0,0,  1, 1,0,0,0);
    add(0,0,0, 0,0,0,  0, 0,1,1,1);
    add(0,0,0, 0,0,0,  0, 0,1,0,1);
    add(0,0,0, 0,1,0,  0, 0,1,0,1);
    // START with Q==0 is ignored
    add(0,1,0, 0,0,0,  0, 0,0,0,1);
    add(0,0,0, 1,0,0,  0, 0,0,0,1);
    // auto-reload with RLD=4, 12 edges
    add(1,0,0, 0,0,0,  0, 0,0,0,0);
    add(0,1,4, 0,0,1,  4, 0,0,0,0);
    add(0,0,0, 1,0,1,  4, 1,0,0,0);
    n = 4'h0;
    for (int i = 1; i <= 12; i++) begin
      if (i % 4 == 0) begin
        n = n + 4'h1;
        add(0,0,0, 0,0,1, 4, 1,0,1,n);
      end else begin
        add(0,0,0, 0,0,1, 4'(4 - i % 4), 1,0,0,n);
      end
    end
    // LOAD while running stays in RUN; pause at 6 for 5 edges
    add(0,1,9, 0,0,0,  9, 1,0,0,3);
    add(0,0,0, 0,0,0,  8, 1,0,0,3);
    add(0,0,0, 0,0,0,  7, 1,0,0,3);
    add(0,0,0, 0,0,0,  6, 1,0,0,3);
    add(0,0,0, 0,1,0,  6, 1,0,0,3);
    for (int i = 0; i < 5; i++) add(0,0,0, 0,0,0, 6, 1,0,0,3);
    add(0,0,0, 1,0,0,  6, 1,0,0,3);
    for (int k = 5; k >= 1; k--) add(0,0,0, 0,0,0, 4'(k), 1,0,0,3);
    add(0,0,0, 0,0,0,  0, 0,1,1,4);
    // restart from DONE, START+STOP in RUN, STOP in PAUSE, START+STOP in IDLE
    add(0,0,0, 1,0,0,  9, 1,0,0,4);
    add(0,0,0, 1,1,0,  9, 1,0,0,4);
    add(0,0,0, 0,1,0,  9, 0,0,0,4);
    add(0,0,0, 1,1,0,  9, 0,0,0,4);
    // LOAD 0 while running drops to IDLE with no pulse
    add(0,0,0, 1,0,0,  9, 1,0,0,4);
    add(0,1,0, 0,0,0,  0, 0,0,0,4);
    // CLEAR mid-count with reload enabled
    add(0,1,3, 0,0,1,  3, 0,0,0,4);
    add(0,0,0, 1,0,1,  3, 1,0,0,4);
    add(0,0,0, 0,0,1,  2, 1,0,0,4);
    add(1,0,0, 0,0,1,  0, 0,0,0,0);
    add(1,1,7, 1,0,1,  0, 0,0,0,0);
    // RLD=1 auto-reload for 17 edges: TC every cycle, TC_CNT wraps
    add(0,1,1, 0,0,1,  1, 0,0,0,0);
    add(0,0,0, 1,0,1,  1, 1,0,0,0);
    n = 4'h0;
    for (int i = 0; i < 17; i++) begin
      n = n + 4'h1;
      add(0,0,0, 0,0,1, 1, 1,0,1,n);
    end
    // pause, then resume with reload disabled: next Q==1 edge finishes
    add(0,0,0, 0,1,1,  1, 1,0,0,1);
    add(0,0,0, 1,0,0,  1, 1,0,0,1);
    add(0,0,0, 0,0,0,  0, 0,1,1,2);
    add(0,0,0, 0,0,0,  0, 0,1,0,2);

    foreach (vecs[i]) begin
      drive(vecs[i].c, vecs[i].l, vecs[i].v, vecs[i].s, vecs[i].p, vecs[i].r);
      @(posedge clk);
      #1;
      act = {q, busy, done, tc, tc_cnt};
      exp = {vecs[i].eq, vecs[i].eb, vecs[i].ed, vecs[i].et, vecs[i].en};
      total++;
      if (act !== exp) begin
        bad++;
        $display("FAIL vec[%0d]: got q=%0d busy=%b done=%b tc=%b tc_cnt=%0d, want q=%0d busy=%b done=%b tc=%b tc_cnt=%0d",
                 i, q, busy, done, tc, tc_cnt,
                 vecs[i].eq, vecs[i].eb, vecs[i].ed, vecs[i].et, vecs[i].en);
      end
    end

    // Latency: START with Q=5 gives TC exactly 5 edges after the START edge
    drive(1, 0, 0, 0, 0, 0); @(posedge clk); #1;
    drive(0, 1, 5, 0, 0, 0); @(posedge clk); #1;
    drive(0, 0, 0, 1, 0, 0); @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0);
    edges = 0;
    while (tc !== 1'b1 && edges < 20) begin
      @(posedge clk); #1;
      edges++;
    end
    total++;
    if (edges != 5) begin
      bad++;
      $display("FAIL latency: got %0d edges, want 5", edges);
    end
    // pulse must be exactly one cycle wide
    @(posedge clk); #1;
    total++;
    if (tc !== 1'b0 || done !== 1'b1 || q !== 4'd0) begin
      bad++;
      $display("FAIL tc_width: got tc=%b done=%b q=%0d, want tc=0 done=1 q=0", tc, done, q);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
